// File: rtl/adder_stimulus_checker.sv
// Stimulus driver and result checker for WIDTH-bit combinational or pipelined adders.
// Issues directed corner vectors, then LFSR vectors, and compares the DUT sum after LAT cycles.
module adder_stimulus_checker #(
   parameter int          WIDTH       = 13,
   parameter int          NUM_VECTORS = 256,
   parameter int          LAT         = 0,
   parameter logic [15:0] SEED1       = 16'hACE1,
   parameter logic [15:0] SEED2       = 16'h1D2B
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   output logic [WIDTH-1:0] o_add_term1,
   output logic [WIDTH-1:0] o_add_term2,
   input  logic [WIDTH:0]   i_result,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [15:0]      o_err_count,
   output logic             o_first_fail_valid,
   output logic [15:0]      o_first_fail_idx
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [15:0]      S1         = (SEED1 == 16'd0) ? 16'd1 : SEED1;
   localparam logic [15:0]      S2         = (SEED2 == 16'd0) ? 16'd1 : SEED2;
   localparam logic [15:0]      LAST_IDX   = 16'(NUM_VECTORS - 1);
   localparam logic [2:0]       DRAIN_INIT = (LAT > 0) ? 3'(LAT - 1) : 3'd0;
   localparam logic [WIDTH-1:0] ALL1       = '1;
   localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
   localparam logic [WIDTH-1:0] ALT_A      = WIDTH'(16'hAAAA);
   localparam logic [WIDTH-1:0] ALT_B      = WIDTH'(16'h5555);

   // Galois step, taps x^16+x^14+x^13+x^11+1
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      lfsr_step = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   logic [1:0]       state_q, state_d;
   logic [15:0]      idx_q, idx_d;
   logic [WIDTH-1:0] t1_q, t1_d, t2_q, t2_d;
   logic [15:0]      l1_q, l1_d, l2_q, l2_d;
   logic [2:0]       drain_q, drain_d;
   logic [15:0]      err_q, err_d;
   logic             ffv_q, ffv_d;
   logic [15:0]      ffi_q, ffi_d;

   logic             start_go;
   logic             vld0;
   logic [WIDTH:0]   exp0;
   logic             chk_vld;
   logic [WIDTH:0]   chk_exp;
   logic [15:0]      chk_idx;
   logic             mismatch;

   assign start_go = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign vld0     = (state_q == ST_RUN);
   assign exp0     = {1'b0, t1_q} + {1'b0, t2_q};

   generate
      if (LAT == 0) begin : g_nodly
         assign chk_vld = vld0;
         assign chk_exp = exp0;
         assign chk_idx = idx_q;
      end else begin : g_dly
         // reference sum travels with its index so the late result meets its own vector
         logic [LAT:1]   vld_pipe_q;
         logic [WIDTH:0] exp_pipe_q [1:LAT];
         logic [15:0]    idx_pipe_q [1:LAT];

         always_ff @(posedge i_clk) begin
            if (i_rst || start_go) begin
               vld_pipe_q <= '0;
               for (int k = 1; k <= LAT; k++) begin
                  exp_pipe_q[k] <= '0;
                  idx_pipe_q[k] <= '0;
               end
            end else begin
               vld_pipe_q[1] <= vld0;
               exp_pipe_q[1] <= exp0;
               idx_pipe_q[1] <= idx_q;
               for (int k = 2; k <= LAT; k++) begin
                  vld_pipe_q[k] <= vld_pipe_q[k-1];
                  exp_pipe_q[k] <= exp_pipe_q[k-1];
                  idx_pipe_q[k] <= idx_pipe_q[k-1];
               end
            end
         end

         assign chk_vld = vld_pipe_q[LAT];
         assign chk_exp = exp_pipe_q[LAT];
         assign chk_idx = idx_pipe_q[LAT];
      end
   endgenerate

   assign mismatch = chk_vld && (i_result != chk_exp);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      t1_d    = t1_q;
      t2_d    = t2_q;
      l1_d    = l1_q;
      l2_d    = l2_q;
      drain_d = drain_q;
      err_d   = err_q;
      ffv_d   = ffv_q;
      ffi_d   = ffi_q;

      if (mismatch) begin
         if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
         if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = chk_idx;
         end
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_go) begin
               state_d = ST_RUN;
               idx_d   = 16'd0;
               t1_d    = '0;
               t2_d    = '0;
               l1_d    = S1;
               l2_d    = S2;
               err_d   = 16'd0;
               ffv_d   = 1'b0;
               ffi_d   = 16'd0;
            end
         end
         ST_RUN: begin
            if (idx_q == LAST_IDX) begin
               state_d = (LAT == 0) ? ST_DONE : ST_DRAIN;
               drain_d = DRAIN_INIT;
            end else begin
               idx_d = idx_q + 16'd1;
               case (idx_d)
                  16'd1: begin t1_d = ALL1;  t2_d = ALL1;  end
                  16'd2: begin t1_d = ALL1;  t2_d = ONE;   end
                  16'd3: begin t1_d = ALT_A; t2_d = ALT_B; end
                  default: begin
                     // first random vector is the seed itself; step after each use
                     t1_d = l1_q[WIDTH-1:0];
                     t2_d = l2_q[WIDTH-1:0];
                     l1_d = lfsr_step(l1_q);
                     l2_d = lfsr_step(l2_q);
                  end
               endcase
            end
         end
         ST_DRAIN: begin
            if (drain_q == 3'd0) state_d = ST_DONE;
            else                 drain_d = drain_q - 3'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 16'd0;
         t1_q    <= '0;
         t2_q    <= '0;
         l1_q    <= S1;
         l2_q    <= S2;
         drain_q <= 3'd0;
         err_q   <= 16'd0;
         ffv_q   <= 1'b0;
         ffi_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         t1_q    <= t1_d;
         t2_q    <= t2_d;
         l1_q    <= l1_d;
         l2_q    <= l2_d;
         drain_q <= drain_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         ffi_q   <= ffi_d;
      end
   end

   assign o_add_term1        = t1_q;
   assign o_add_term2        = t2_q;
   assign o_busy             = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign o_done             = (state_q == ST_DONE);
   assign o_pass             = o_done && (err_q == 16'd0);
   assign o_err_count        = err_q;
   assign o_first_fail_valid = ffv_q;
   assign o_first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_adder_stimulus_checker.sv
// Bench for adder_stimulus_checker: several checker instances against ideal, faulty and
// registered adders, compared each cycle with a run-level model of the expected outputs.
module tb_adder_stimulus_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, st_a, rst_c, st_c;
   logic chk_en;
   int   n_cmp = 0;
   int   n_fail = 0;

   // A: ideal, B: carry-out stuck at 0, F: WIDTH=4 ideal (all LAT=0, share rst_a/st_a)
   logic [12:0] a_t1, a_t2, b_t1, b_t2, c_t1, c_t2, d_t1, d_t2, e_t1, e_t2;
   logic [3:0]  f_t1, f_t2;
   logic [13:0] a_res, b_res, c_res, d_res, e_res;
   logic [4:0]  f_res;
   logic        a_bsy, a_dn, a_ps, a_fv, b_bsy, b_dn, b_ps, b_fv, f_bsy, f_dn, f_ps, f_fv;
   logic        c_bsy, c_dn, c_ps, c_fv, d_bsy, d_dn, d_ps, d_fv, e_bsy, e_dn, e_ps, e_fv;
   logic [15:0] a_ec, a_fi, b_ec, b_fi, f_ec, f_fi, c_ec, c_fi, d_ec, d_fi, e_ec, e_fi;
   logic [13:0] c_r1 = '0, c_r2 = '0, d_r1 = '0, d_r2 = '0;

   assign a_res = {1'b0, a_t1} + {1'b0, a_t2};
   assign b_res = ({1'b0, b_t1} + {1'b0, b_t2}) & 14'h1FFF;
   assign f_res = {1'b0, f_t1} + {1'b0, f_t2};
   assign c_res = c_r2;
   assign d_res = d_r2;
   assign e_res = {1'b0, e_t1} + {1'b0, e_t2} + 14'd1;

   always @(posedge clk) begin
      c_r1 <= {1'b0, c_t1} + {1'b0, c_t2};
      c_r2 <= c_r1;
      d_r1 <= {1'b0, d_t1} + {1'b0, d_t2};
      d_r2 <= d_r1;
   end

   adder_stimulus_checker #(.WIDTH(13), .NUM_VECTORS(16), .LAT(0)) u_a (
      .i_clk(clk), .i_rst(rst_a), .i_start(st_a), .o_add_term1(a_t1), .o_add_term2(a_t2),
      .i_result(a_res), .o_busy(a_bsy), .o_done(a_dn), .o_pass(a_ps), .o_err_count(a_ec),
      .o_first_fail_valid(a_fv), .o_first_fail_idx(a_fi));
   adder_stimulus_checker #(.WIDTH(13), .NUM_VECTORS(16), .LAT(0)) u_b (
      .i_clk(clk), .i_rst(rst_a), .i_start(st_a), .o_add_term1(b_t1), .o_add_term2(b_t2),
      .i_result(b_res), .o_busy(b_bsy), .o_done(b_dn), .o_pass(b_ps), .o_err_count(b_ec),
      .o_first_fail_valid(b_fv), .o_first_fail_idx(b_fi));
   adder_stimulus_checker #(.WIDTH(4), .NUM_VECTORS(8), .LAT(0)) u_f (
      .i_clk(clk), .i_rst(rst_a), .i_start(st_a), .o_add_term1(f_t1), .o_add_term2(f_t2),
      .i_result(f_res), .o_busy(f_bsy), .o_done(f_dn), .o_pass(f_ps), .o_err_count(f_ec),
      .o_first_fail_valid(f_fv), .o_first_fail_idx(f_fi));
   adder_stimulus_checker #(.WIDTH(13), .NUM_VECTORS(16), .LAT(2)) u_c (
      .i_clk(clk), .i_rst(rst_c), .i_start(st_c), .o_add_term1(c_t1), .o_add_term2(c_t2),
      .i_result(c_res), .o_busy(c_bsy), .o_done(c_dn), .o_pass(c_ps), .o_err_count(c_ec),
      .o_first_fail_valid(c_fv), .o_first_fail_idx(c_fi));
   adder_stimulus_checker #(.WIDTH(13), .NUM_VECTORS(16), .LAT(1)) u_d (
      .i_clk(clk), .i_rst(rst_c), .i_start(st_c), .o_add_term1(d_t1), .o_add_term2(d_t2),
      .i_result(d_res), .o_busy(d_bsy), .o_done(d_dn), .o_pass(d_ps), .o_err_count(d_ec),
      .o_first_fail_valid(d_fv), .o_first_fail_idx(d_fi));
   adder_stimulus_checker #(.WIDTH(13), .NUM_VECTORS(65535), .LAT(0)) u_e (
      .i_clk(clk), .i_rst(rst_c), .i_start(st_c), .o_add_term1(e_t1), .o_add_term2(e_t2),
      .i_result(e_res), .o_busy(e_bsy), .o_done(e_dn), .o_pass(e_ps), .o_err_count(e_ec),
      .o_first_fail_valid(e_fv), .o_first_fail_idx(e_fi));

   // ---------------- model ----------------
   function automatic logic [15:0] gal(input logic [15:0] s);
      gal = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   // vector i as {term1, term2}, 16 bits each
   function automatic logic [31:0] mvec(input int w, input int i);
      logic [15:0] m, l1, l2;
      m  = 16'((32'd1 << w) - 32'd1);
      l1 = 16'hACE1;
      l2 = 16'h1D2B;
      if (i == 0) return 32'd0;
      if (i == 1) return {m, m};
      if (i == 2) return {m, 16'd1};
      if (i == 3) return {16'hAAAA & m, 16'h5555 & m};
      for (int k = 4; k < i; k++) begin
         l1 = gal(l1);
         l2 = gal(l2);
      end
      return {l1 & m, l2 & m};
   endfunction

   function automatic int msum(input int w, input int i);
      logic [31:0] v;
      v = mvec(w, i);
      return int'(v[31:16]) + int'(v[15:0]);
   endfunction

   // kind 0: ideal adder; 1: carry-out stuck low; 2: two-register adder read one cycle early
   function automatic bit mbad(input int kind, input int w, input int i);
      int s;
      s = msum(w, i);
      if (kind == 1) return ((s >> w) & 1) == 1;
      if (kind == 2) return s != ((i == 0) ? 0 : msum(w, i - 1));
      return 1'b0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // t = cycles since the honoured start (t=1 is the first cycle after the start edge)
   task automatic grp_chk(input string g, input int w, input int n, input int lat, input int kind,
                          input int t, input bit run, input logic [15:0] t1, input logic [15:0] t2,
                          input logic bsy, input logic dn, input logic ps, input logic [15:0] ec,
                          input logic fv, input logic [15:0] fi);
      logic [31:0] v;
      int upto, ne, fidx;
      bit ebusy, edone;
      v = 32'd0; ebusy = 1'b0; edone = 1'b0; ne = 0; fidx = 0;
      if (run) begin
         v     = mvec(w, ((t < n) ? t : n) - 1);
         ebusy = (t <= n + lat);
         edone = !ebusy;
         upto  = t - 2 - lat;
         if (upto > n - 1) upto = n - 1;
         fidx = -1;
         for (int i = 0; i <= upto; i++)
            if (mbad(kind, w, i)) begin
               ne++;
               if (fidx < 0) fidx = i;
            end
         if (fidx < 0) fidx = 0;
      end
      chk({g, "_term1"}, {16'd0, t1}, {16'd0, v[31:16]});
      chk({g, "_term2"}, {16'd0, t2}, {16'd0, v[15:0]});
      chk({g, "_busy"}, {31'd0, bsy}, {31'd0, ebusy});
      chk({g, "_done"}, {31'd0, dn}, {31'd0, edone});
      chk({g, "_pass"}, {31'd0, ps}, {31'd0, (edone && ne == 0)});
      chk({g, "_err"}, {16'd0, ec}, 32'(ne));
      chk({g, "_ffv"}, {31'd0, fv}, {31'd0, (ne > 0)});
      chk({g, "_ffi"}, {16'd0, fi}, 32'(fidx));
   endtask

   int t_a = 0, t_f = 0, t_c = 0, nrun_a = 0;
   bit run_a = 1'b0, run_f = 1'b0, run_c = 1'b0;

   always @(posedge clk) begin
      if (rst_a) begin
         run_a <= 1'b0; t_a <= 0; run_f <= 1'b0; t_f <= 0;
      end else begin
         if (st_a && !(run_a && t_a <= 16)) begin
            run_a <= 1'b1; t_a <= 1; nrun_a <= nrun_a + 1;
         end else if (run_a) t_a <= t_a + 1;
         if (st_a && !(run_f && t_f <= 8)) begin
            run_f <= 1'b1; t_f <= 1;
         end else if (run_f) t_f <= t_f + 1;
      end
      if (rst_c) begin
         run_c <= 1'b0; t_c <= 0;
      end else if (st_c && !(run_c && t_c <= 18)) begin
         run_c <= 1'b1; t_c <= 1;
      end else if (run_c) t_c <= t_c + 1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         grp_chk("A", 13, 16, 0, 0, t_a, run_a, {3'd0, a_t1}, {3'd0, a_t2}, a_bsy, a_dn, a_ps, a_ec, a_fv, a_fi);
         grp_chk("B", 13, 16, 0, 1, t_a, run_a, {3'd0, b_t1}, {3'd0, b_t2}, b_bsy, b_dn, b_ps, b_ec, b_fv, b_fi);
         grp_chk("F", 4, 8, 0, 0, t_f, run_f, {12'd0, f_t1}, {12'd0, f_t2}, f_bsy, f_dn, f_ps, f_ec, f_fv, f_fi);
         grp_chk("C", 13, 16, 2, 0, t_c, run_c, {3'd0, c_t1}, {3'd0, c_t2}, c_bsy, c_dn, c_ps, c_ec, c_fv, c_fi);
         grp_chk("D", 13, 16, 1, 2, t_c, run_c, {3'd0, d_t1}, {3'd0, d_t2}, d_bsy, d_dn, d_ps, d_ec, d_fv, d_fi);
         // hand-computed pins for the first run
         if (run_a && nrun_a == 1) begin
            if (t_a == 1) chk("pin_v0", {3'd0, a_t1, 3'd0, a_t2}, 32'h0000_0000);
            if (t_a == 2) chk("pin_v1", {3'd0, a_t1, 3'd0, a_t2}, 32'h1FFF_1FFF);
            if (t_a == 3) chk("pin_v2", {3'd0, a_t1, 3'd0, a_t2}, 32'h1FFF_0001);
            if (t_a == 4) chk("pin_v3", {3'd0, a_t1, 3'd0, a_t2}, 32'h0AAA_1555);
            if (t_a == 5) chk("pin_v4", {3'd0, a_t1, 3'd0, a_t2}, 32'h0CE1_1D2B);
            if (t_a == 6) chk("pin_v5", {3'd0, a_t1, 3'd0, a_t2}, 32'h0270_1A95);
            if (t_a == 2) chk("pin_b_res_v1", {18'd0, b_res}, 32'h1FFE);
            if (t_a == 16) chk("pin_a_done16", {31'd0, a_dn}, 32'd0);
            if (t_a == 17) chk("pin_a_pass17", {30'd0, a_dn, a_ps}, 32'd3);
            if (t_a == 17) chk("pin_b_ffi", {15'd0, b_fv, b_fi}, 32'h1_0001);
            if (t_a == 17) chk("pin_b_pass", {31'd0, b_ps}, 32'd0);
         end
         if (run_f && t_f == 4) chk("pin_f_v3", {12'd0, f_t1, 12'd0, f_t2}, 32'h000A_0005);
         if (run_c && t_c == 18) chk("pin_c_done18", {31'd0, c_dn}, 32'd0);
         if (run_c && t_c == 19) chk("pin_c_pass19", {30'd0, c_dn, c_ps}, 32'd3);
         if (run_c && t_c == 19) chk("pin_d_fail", {30'd0, (d_ec > 16'd0), d_ps}, 32'd2);
      end
   end

   task automatic pulse_a();
      st_a = 1'b1;
      @(posedge clk); #1 st_a = 1'b0;
   endtask

   initial begin
      rst_a = 1'b1; rst_c = 1'b1; st_a = 1'b0; st_c = 1'b0; chk_en = 1'b0;
      @(posedge clk); #1 chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_a = 1'b0; rst_c = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // run 1 for all instances; re-pulse during RUN is ignored
      st_c = 1'b1;
      pulse_a();
      st_c = 1'b0;
      repeat (5) @(posedge clk);
      #1 pulse_a();
      repeat (20) @(posedge clk);
      #1;
      // run 2 from DONE: same sequence replayed
      pulse_a();
      repeat (22) @(posedge clk);
      #1;
      // run 3: reset during RUN cycle 7
      pulse_a();
      repeat (6) @(posedge clk);
      #1 rst_a = 1'b1;
      @(posedge clk); #1 rst_a = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      // run 4: full run after the abort
      pulse_a();
      repeat (22) @(posedge clk);
      #1 chk_en = 1'b0;
      // every-vector mismatch over 65535 vectors
      for (int k = 0; k < 70000 && !e_dn; k++) @(posedge clk);
      @(negedge clk);
      chk("E_done", {31'd0, e_dn}, 32'd1);
      chk("E_err", {16'd0, e_ec}, 32'h0000_FFFF);
      chk("E_ff", {15'd0, e_fv, e_fi}, 32'h1_0000);
      chk("E_pass_busy", {30'd0, e_ps, e_bsy}, 32'd0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("E_err_hold", {16'd0, e_ec}, 32'h0000_FFFF);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
